fetch_sequencer: RTL and testbench

// Program-counter sequencer and IF/ID register for the 9-bit pipelined CPU. Drives the address of
// the combinational instruction ROM and registers each returned word plus its PC into the IF/ID

---
 rtl/fetch_sequencer_if.sv | 31 +++
 rtl/fetch_sequencer.sv | 150 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Bundle of control, ROM and IF/ID signals exchanged between the fetch
// sequencer and the rest of the 9-bit pipelined CPU.
// master: the sequencer itself (drives ROM address and the IF/ID stage)
// slave : the surrounding pipeline / ROM (drives control and ROM data)
interface fetch_sequencer_if #(
    parameter int PC_W   = 16,
    parameter int INST_W = 9
);
    logic              start;
    logic              stall;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic [INST_W-1:0] rom_inst;
    logic [PC_W-1:0]   rom_pc;
    logic              if_valid;
    logic [INST_W-1:0] if_inst;
    logic [PC_W-1:0]   if_pc;
    logic              running;
    logic              halted;
    logic [15:0]       fetch_count;

    modport master (
        input  start, stall, redirect_valid, redirect_pc, rom_inst,
        output rom_pc, if_valid, if_inst, if_pc, running, halted, fetch_count
    );

    modport slave (
        output start, stall, redirect_valid, redirect_pc, rom_inst,
        input  rom_pc, if_valid, if_inst, if_pc, running, halted, fetch_count
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer and IF/ID register. Presents pc to a
// combinational instruction ROM, latches the returned word with its PC,
// and handles start, decode stall, redirect/flush and halt detection.
// rom_pc is taken straight from the PC register, so there is never a
// combinational path from inputs back through the ROM.
module fetch_sequencer #(
    parameter int              PC_W     = 16,
    parameter int              INST_W   = 9,
    parameter logic [PC_W-1:0] START_PC = PC_W'(1),
    parameter logic [4:0]      HALT_OP  = 5'b11010
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_sequencer_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [PC_W-1:0]   pc_reg, pc_next;
    logic              if_valid_reg, if_valid_next;
    logic [INST_W-1:0] if_inst_reg, if_inst_next;
    logic [PC_W-1:0]   if_pc_reg, if_pc_next;
    logic [15:0]       fetch_count_reg, fetch_count_next;
    logic              running_reg, halted_reg;

    // Opcode field of the word currently returned by the ROM.
    logic [4:0] rom_opcode;
    logic       rom_is_halt;
    logic [15:0] fetch_count_inc;

    assign rom_opcode      = bus.rom_inst[INST_W-1 -: 5];
    assign rom_is_halt     = (rom_opcode == HALT_OP);
    assign fetch_count_inc = (fetch_count_reg == 16'hFFFF) ? fetch_count_reg
                                                           : fetch_count_reg + 16'd1;

    // State and IF/ID registers; running/halted are registered decodes of the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            pc_reg          <= START_PC;
            if_valid_reg    <= 1'b0;
            if_inst_reg     <= '0;
            if_pc_reg       <= '0;
            fetch_count_reg <= 16'd0;
            running_reg     <= 1'b0;
            halted_reg      <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            if_valid_reg    <= if_valid_next;
            if_inst_reg     <= if_inst_next;
            if_pc_reg       <= if_pc_next;
            fetch_count_reg <= fetch_count_next;
            running_reg     <= (state_next == RUN);
            halted_reg      <= (state_next == HALTED);
        end
    end

    // Next-state: redirect beats start out of HALTED; start is ignored while running.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!bus.redirect_valid && !bus.stall && rom_is_halt) begin
                    state_next = HALTED;
                end
            end
            HALTED: begin
                if (bus.redirect_valid || bus.start) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath next values: priority redirect > stall > fetch while running.
    always_comb begin
        pc_next          = pc_reg;
        if_valid_next    = if_valid_reg;
        if_inst_next     = if_inst_reg;
        if_pc_next       = if_pc_reg;
        fetch_count_next = fetch_count_reg;
        case (state_reg)
            IDLE: begin
                // Parked at the entry point with an empty IF/ID stage.
                pc_next       = START_PC;
                if_valid_next = 1'b0;
                if (bus.start) begin
                    fetch_count_next = 16'd0;
                end
            end
            RUN: begin
                if (bus.redirect_valid) begin
                    // Flush: the word at the old pc is discarded, IF/ID data keeps its value.
                    pc_next       = bus.redirect_pc;
                    if_valid_next = 1'b0;
                end else if (!bus.stall) begin
                    if_inst_next     = bus.rom_inst;
                    if_pc_next       = pc_reg;
                    if_valid_next    = 1'b1;
                    fetch_count_next = fetch_count_inc;
                    // The halt word itself is delivered; pc stays parked on it.
                    if (!rom_is_halt) begin
                        pc_next = pc_reg + PC_W'(1);
                    end
                end
            end
            HALTED: begin
                if (bus.redirect_valid) begin
                    // Halt was fetched in the shadow of a taken branch.
                    pc_next       = bus.redirect_pc;
                    if_valid_next = 1'b0;
                end else if (bus.start) begin
                    pc_next          = START_PC;
                    if_valid_next    = 1'b0;
                    fetch_count_next = 16'd0;
                end else if (!bus.stall) begin
                    // Decode has consumed the halt word.
                    if_valid_next = 1'b0;
                end
            end
            default: begin
                pc_next       = START_PC;
                if_valid_next = 1'b0;
            end
        endcase
    end

    assign bus.rom_pc      = pc_reg;
    assign bus.if_valid    = if_valid_reg;
    assign bus.if_inst     = if_inst_reg;
    assign bus.if_pc       = if_pc_reg;
    assign bus.running     = running_reg;
    assign bus.halted      = halted_reg;
    assign bus.fetch_count = fetch_count_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, a hand-written
// reset/latency sequence, then random stimulus against a behavioural model.
module tb_fetch_sequencer;

    logic clk;
    logic rst_n;

    fetch_sequencer_if ifc ();

    fetch_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction ROM, combinational read.
    logic [8:0] rom [0:65535];
    assign ifc.rom_inst = rom[ifc.rom_pc];

    int tests = 0;
    int fails = 0;

    // Behavioural model: mode 0 idle, 1 running, 2 halted.
    int          m_mode;
    logic [15:0] m_pc;
    logic        m_valid;
    logic [8:0]  m_inst;
    logic [15:0] m_ipc;
    logic [15:0] m_cnt;

    typedef struct {
        bit          r;
        bit          s;
        bit          st;
        bit          rv;
        logic [15:0] rpc;
        logic [15:0] e_pc;
        bit          e_v;
        logic [15:0] e_ipc;
        logic [8:0]  e_inst;
        bit          e_run;
        bit          e_halt;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs [28];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model update from the rules, using the ROM word at the model's own pc.
    task automatic model_step(input bit r, input bit s, input bit st, input bit rv,
                              input logic [15:0] rpc);
        logic [8:0] w;
        w = rom[m_pc];
        if (!r) begin
            m_mode = 0; m_pc = 16'd1; m_valid = 1'b0;
            m_inst = 9'd0; m_ipc = 16'd0; m_cnt = 16'd0;
        end else if (m_mode == 0) begin
            m_pc = 16'd1;
            m_valid = 1'b0;
            if (s) begin
                m_mode = 1;
                m_cnt = 16'd0;
            end
        end else if (m_mode == 1) begin
            if (rv) begin
                m_pc = rpc;
                m_valid = 1'b0;
            end else if (!st) begin
                m_inst = w;
                m_ipc = m_pc;
                m_valid = 1'b1;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                if (w[8:4] == 5'b11010) m_mode = 2;
                else m_pc = 16'((32'(m_pc) + 1) % 65536);
            end
        end else begin
            if (rv) begin
                m_pc = rpc; m_valid = 1'b0; m_mode = 1;
            end else if (s) begin
                m_pc = 16'd1; m_valid = 1'b0; m_cnt = 16'd0; m_mode = 1;
            end else if (!st) begin
                m_valid = 1'b0;
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model, then sample 1 time unit after the edge.
    task automatic drive(input bit r, input bit s, input bit st, input bit rv,
                         input logic [15:0] rpc);
        rst_n = r;
        ifc.start = s;
        ifc.stall = st;
        ifc.redirect_valid = rv;
        ifc.redirect_pc = rpc;
        model_step(r, s, st, rv, rpc);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".rom_pc"},      32'(ifc.rom_pc),      32'(m_pc));
        chk({tag, ".if_valid"},    32'(ifc.if_valid),    32'(m_valid));
        chk({tag, ".if_inst"},     32'(ifc.if_inst),     32'(m_inst));
        chk({tag, ".if_pc"},       32'(ifc.if_pc),       32'(m_ipc));
        chk({tag, ".running"},     32'(ifc.running),     32'(m_mode == 1));
        chk({tag, ".halted"},      32'(ifc.halted),      32'(m_mode == 2));
        chk({tag, ".fetch_count"}, 32'(ifc.fetch_count), 32'(m_cnt));
    endtask

    initial begin
        bit          r, s, st, rv;
        logic [15:0] rpc;
        string       tag;

        rst_n = 1'b0;
        ifc.start = 1'b0;
        ifc.stall = 1'b0;
        ifc.redirect_valid = 1'b0;
        ifc.redirect_pc = 16'd0;

        // ROM: random contents, then fixed words used by the directed vectors.
        for (int i = 0; i < 65536; i++) rom[i] = 9'($urandom);
        for (int i = 1; i <= 13; i++) rom[i] = {5'(i), 4'(i)};
        rom[14]      = 9'b110100000;
        rom[16'h40]  = 9'h0A5;
        rom[16'hFFFF] = 9'h0FF;

        vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,16'h0000, 16'h0001,1'b0,16'h0000,9'h000,1'b0,1'b0,16'd0};
        vecs[1]  = '{1'b1,1'b0,1'b1,1'b1,16'h0040, 16'h0001,1'b0,16'h0000,9'h000,1'b0,1'b0,16'd0};
        vecs[2]  = '{1'b1,1'b1,1'b0,1'b0,16'h0000, 16'h0001,1'b0,16'h0000,9'h000,1'b1,1'b0,16'd0};
        vecs[3]  = '{1'b1,1'b0,1'b0,1'b0,16'h0000, 16'h0002,1'b1,16'h0001,9'h011,1'b1,1'b0,16'd1};
        vecs[4]  = '{1'b1,1'b0,1'b0,1'b0,16'h0000, 16'h0003,1'b1,16'h0002,9'h022,1'b1,1'b0,16'd2};
        vecs[5]  = '{1'b1,1'b0,1'b0,1'b0,16'h0000, 16'h0004,1'b1,16'h0003,9'h033,1'b1,1'b0,16'd3};
        vecs[6]  = '{1'b1,1'b1,1'b0,1'b0,16'h0000, 16'h0005,1'b1,16'h0004,9'h044,1'b1,1'b0,16'd4};
        vecs[7]  = '{1'b1,1'b0,1'b1,1'b0,16'h0000, 16'h0005,1'b1,16'h0004,9'h044,1'b1,1'b0,16'd4};
        vecs[8]  = '{1'b1,1'b0,1'b1,1'b0,16'h0000, 16'h0005,1'b1,16'h0004,9'h044,1'b1,1'b0,16'd4};
        vecs[9]  = '{1'b1,1'b0,1'b1,1'b0,16'h0000, 16'h0005,1'b1,16'h0004,9'h044,1'b1,1'b0,16'd4};
        vecs[10] = '{1'b1,1'b0,1'b1,1'b1,16'h0040, 16'h0040,1'b0,16'h0004,9'h044,1'b1,1'b0,16'd4};
        vecs[11] = '{1'b1,1'b0,1'b0,1'b0,16'h0000, 16'h0041,1'b1,16'h0040,9'h0A5,1'b1,1'b0,16'd5};
        vecs[12] = '{1'b1,1'b0,1'b0,1'b1,16'h000E, 16'h000E,1'b0,16'h0040,9'h0A5,1'b1,1'b0,16'd5};
        vecs[13] = '{1'b1,1'b0,1'b0,1'b0,16'h0000, 16'h000E,1'b1,16'h000E,9'h1A0,1'b0,1'b1,16'd6};
        vecs[14] = '{1'b1,1'b0,1'b1,1'b0,16'h0000, 16'h000E,1'b1,16'h000E,9'h1A0,1'b0,1'b1,16'd6};
        vecs[15] = '{1'b1,1'b0,1'b0,1'b0,16'h0000, 16'h000E,1'b0,16'h000E,9'h1A0,1'b0,1'b1,16'd6};
        vecs[16] = '{1'b1,1'b0,1'b0,1'b1,16'h0008, 16'h0008,1'b0,16'h000E,9'h1A0,1'b1,1'b0,16'd6};
        vecs[17] = '{1'b1,1'b0,1'b0,1'b0,16'h0000, 16'h0009,1'b1,16'h0008,9'h088,1'b1,1'b0,16'd7};
        vecs[18] = '{1'b1,1'b0,1'b0,1'b1,16'h000E, 16'h000E,1'b0,16'h0008,9'h088,1'b1,1'b0,16'd7};
        vecs[19] = '{1'b1,1'b0,1'b0,1'b0,16'h0000, 16'h000E,1'b1,16'h000E,9'h1A0,1'b0,1'b1,16'd8};
        vecs[20] = '{1'b1,1'b1,1'b0,1'b1,16'h0020, 16'h0020,1'b0,16'h000E,9'h1A0,1'b1,1'b0,16'd8};
        vecs[21] = '{1'b1,1'b0,1'b0,1'b1,16'h000E, 16'h000E,1'b0,16'h000E,9'h1A0,1'b1,1'b0,16'd8};
        vecs[22] = '{1'b1,1'b0,1'b0,1'b0,16'h0000, 16'h000E,1'b1,16'h000E,9'h1A0,1'b0,1'b1,16'd9};
        vecs[23] = '{1'b1,1'b1,1'b0,1'b0,16'h0000, 16'h0001,1'b0,16'h000E,9'h1A0,1'b1,1'b0,16'd0};
        vecs[24] = '{1'b1,1'b0,1'b0,1'b0,16'h0000, 16'h0002,1'b1,16'h0001,9'h011,1'b1,1'b0,16'd1};
        vecs[25] = '{1'b1,1'b0,1'b0,1'b1,16'hFFFF, 16'hFFFF,1'b0,16'h0001,9'h011,1'b1,1'b0,16'd1};
        vecs[26] = '{1'b1,1'b0,1'b0,1'b0,16'h0000, 16'h0000,1'b1,16'hFFFF,9'h0FF,1'b1,1'b0,16'd2};
        vecs[27] = '{1'b0,1'b0,1'b1,1'b0,16'h0000, 16'h0001,1'b0,16'h0000,9'h000,1'b0,1'b0,16'd0};

        @(negedge clk);

        // Directed table.
        for (int i = 0; i < 28; i++) begin
            drive(vecs[i].r, vecs[i].s, vecs[i].st, vecs[i].rv, vecs[i].rpc);
            tag = $sformatf("vec%0d", i);
            chk({tag, ".rom_pc"},      32'(ifc.rom_pc),      32'(vecs[i].e_pc));
            chk({tag, ".if_valid"},    32'(ifc.if_valid),    32'(vecs[i].e_v));
            chk({tag, ".if_pc"},       32'(ifc.if_pc),       32'(vecs[i].e_ipc));
            chk({tag, ".if_inst"},     32'(ifc.if_inst),     32'(vecs[i].e_inst));
            chk({tag, ".running"},     32'(ifc.running),     32'(vecs[i].e_run));
            chk({tag, ".halted"},      32'(ifc.halted),      32'(vecs[i].e_halt));
            chk({tag, ".fetch_count"}, 32'(ifc.fetch_count), 32'(vecs[i].e_cnt));
            $display("[TB] vec %0d rom_pc=%0h if_valid=%0b if_pc=%0h count=%0d",
                     i, ifc.rom_pc, ifc.if_valid, ifc.if_pc, ifc.fetch_count);
        end

        // Hand sequence: redirect latency, then reset while halted and stalled.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000); check_model("seq.rst");
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000); check_model("seq.start");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000); check_model("seq.f1");
        drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0007); check_model("seq.redir");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000); check_model("seq.lat1");
        chk("seq.first_target_pc", 32'(ifc.if_pc), 32'h7);
        chk("seq.first_target_valid", 32'(ifc.if_valid), 32'h1);
        for (int k = 0; k < 7; k++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
            check_model($sformatf("seq.run%0d", k));
        end
        chk("seq.halted_at_14", 32'(ifc.halted), 32'h1);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000); check_model("seq.hstall");
        drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h0030); check_model("seq.rst_mid");
        $display("[TB] hand sequence done rom_pc=%0h halted=%0b", ifc.rom_pc, ifc.halted);

        // Random stimulus against the model.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        check_model("rnd.rst");
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 199) != 0);
            s  = ($urandom_range(0, 7) == 0);
            st = ($urandom_range(0, 3) == 0);
            rv = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 15) == 0) rpc = 16'hFFFF - 16'($urandom_range(0, 3));
            else rpc = 16'($urandom_range(0, 80));
            drive(r, s, st, rv, rpc);
            check_model($sformatf("rnd%0d", n));
            if (n % 500 == 0)
                $display("[TB] rnd %0d rom_pc=%0h if_valid=%0b mode=%0d count=%0d",
                         n, ifc.rom_pc, ifc.if_valid, m_mode, ifc.fetch_count);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
